// File: rtl/run_monitor_pkg.sv
// Shared constants and state encoding for the end-of-run monitor.
// Default parameter values are kept here so the top and the dump stream agree.
package run_monitor_pkg;

    typedef enum logic [1:0] {
        StRun,
        StDump,
        StHalt
    } state_e;

    localparam int unsigned DefDataW     = 32;
    localparam int unsigned DefDoneAddr  = 100;
    localparam int unsigned DefDumpFirst = 50;
    localparam int unsigned DefDumpCount = 60;
    localparam int unsigned DefCycMax    = 100000;
    localparam int unsigned DefCntW      = 32;

    localparam int unsigned IdxW      = 7;
    localparam int unsigned DumpAddrW = 16;

endpackage

// File: rtl/run_dump_stream.sv
// Result-window reader: word counter feeding a single-entry valid/ready output register.
// Loads a new word whenever the register is empty or being drained in the same cycle.
module run_dump_stream
    import run_monitor_pkg::*;
#(
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned DUMP_COUNT = DefDumpCount
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              active,
    input  logic [DATA_W-1:0] rdata,
    input  logic              ready,
    output logic [IdxW-1:0]   rd_idx,
    output logic [DATA_W-1:0] data,
    output logic [IdxW-1:0]   data_idx,
    output logic              valid,
    output logic              last_accept
);

    logic [IdxW-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [IdxW-1:0]   data_idx_q, data_idx_d;
    logic              valid_q, valid_d;
    logic              load, accept;

    assign accept = valid_q && ready;
    assign load   = active && (idx_q < IdxW'(DUMP_COUNT)) && (!valid_q || ready);

    always_comb begin
        idx_d      = idx_q;
        data_d     = data_q;
        data_idx_d = data_idx_q;
        valid_d    = valid_q;
        if (load) begin
            data_d     = rdata;
            data_idx_d = idx_q;
            valid_d    = 1'b1;
            idx_d      = idx_q + 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            data_q     <= '0;
            data_idx_q <= '0;
            valid_q    <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            data_q     <= data_d;
            data_idx_q <= data_idx_d;
            valid_q    <= valid_d;
        end
    end

    assign rd_idx      = idx_q;
    assign data        = data_q;
    assign data_idx    = data_idx_q;
    assign valid       = valid_q;
    assign last_accept = accept && (data_idx_q == IdxW'(DUMP_COUNT - 1));

endmodule

// File: rtl/run_monitor.sv
// End-of-run monitor: counts cycles/stalls, catches the completion store,
// then streams the dmem result window out through a valid/ready port.
module run_monitor
    import run_monitor_pkg::*;
#(
    parameter int unsigned DATA_W     = DefDataW,
    parameter int unsigned DONE_ADDR  = DefDoneAddr,
    parameter int unsigned DUMP_FIRST = DefDumpFirst,
    parameter int unsigned DUMP_COUNT = DefDumpCount,
    parameter int unsigned CYC_MAX    = DefCycMax,
    parameter int unsigned CNT_W      = DefCntW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall_in,
    input  logic [DATA_W-1:0]    daddr,
    input  logic [DATA_W-1:0]    dwdata,
    input  logic                 dwe,
    output logic [DumpAddrW-1:0] dump_addr,
    input  logic [DATA_W-1:0]    dump_rdata,
    output logic [DATA_W-1:0]    dump_data,
    output logic [IdxW-1:0]      dump_idx,
    output logic                 dump_valid,
    input  logic                 dump_ready,
    output logic                 done,
    output logic                 timeout,
    output logic [DATA_W-1:0]    result,
    output logic [CNT_W-1:0]     cycle_count,
    output logic [CNT_W-1:0]     stall_count,
    output logic                 dump_end
);

    state_e            state_q, state_d;
    logic              done_q, done_d;
    logic              timeout_q, timeout_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [CNT_W-1:0]  stall_q, stall_d;
    logic              hit, last_accept;
    logic [IdxW-1:0]   rd_idx;

    assign hit = dwe && (daddr == DATA_W'(DONE_ADDR));

    always_comb begin
        state_d   = state_q;
        done_d    = done_q;
        timeout_d = timeout_q;
        result_d  = result_q;
        cycle_d   = cycle_q;
        stall_d   = stall_q;
        unique case (state_q)
            StRun: begin
                // The completion cycle itself is not counted, and it beats a timeout.
                if (hit) begin
                    result_d = dwdata;
                    done_d   = 1'b1;
                    state_d  = StDump;
                end else begin
                    cycle_d = cycle_q + 1'b1;
                    stall_d = stall_q + CNT_W'(stall_in);
                    if (cycle_q == CNT_W'(CYC_MAX - 1)) begin
                        timeout_d = 1'b1;
                        state_d   = StHalt;
                    end
                end
            end
            StDump: begin
                if (last_accept) state_d = StHalt;
            end
            StHalt: ;
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StRun;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
            result_q  <= '0;
            cycle_q   <= '0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            done_q    <= done_d;
            timeout_q <= timeout_d;
            result_q  <= result_d;
            cycle_q   <= cycle_d;
            stall_q   <= stall_d;
        end
    end

    run_dump_stream #(
        .DATA_W     (DATA_W),
        .DUMP_COUNT (DUMP_COUNT)
    ) u_dump (
        .clk         (clk),
        .rst         (rst),
        .active      (state_q == StDump),
        .rdata       (dump_rdata),
        .ready       (dump_ready),
        .rd_idx      (rd_idx),
        .data        (dump_data),
        .data_idx    (dump_idx),
        .valid       (dump_valid),
        .last_accept (last_accept)
    );

    assign dump_addr   = (state_q == StDump) ? DumpAddrW'(DUMP_FIRST) + DumpAddrW'(rd_idx)
                                             : DumpAddrW'(DUMP_FIRST);
    assign dump_end    = last_accept && (state_q == StDump);
    assign done        = done_q;
    assign timeout     = timeout_q;
    assign result      = result_q;
    assign cycle_count = cycle_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_run_monitor.sv
// Bench for run_monitor: table of per-cycle vectors for counting/completion, then
// hand-written dump, reset and timeout sequences against a dmem model mem[i] = i*3.
module tb_run_monitor;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, stall_in = 1'b0, dwe = 1'b0, dump_ready = 1'b0;
    logic [31:0] daddr = '0, dwdata = '0;
    logic [15:0] dump_addr;
    logic [31:0] dump_rdata, dump_data, result, cycle_count, stall_count;
    logic [6:0]  dump_idx;
    logic        dump_valid, done, timeout, dump_end;

    assign dump_rdata = 32'(dump_addr) * 32'd3;

    run_monitor dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
        .dump_addr(dump_addr), .dump_rdata(dump_rdata), .dump_data(dump_data),
        .dump_idx(dump_idx), .dump_valid(dump_valid), .dump_ready(dump_ready), .done(done),
        .timeout(timeout), .result(result), .cycle_count(cycle_count),
        .stall_count(stall_count), .dump_end(dump_end)
    );

    // Short-budget instance for the timeout corner.
    logic        t_rst = 1'b1, t_stall = 1'b0, t_dwe = 1'b0;
    logic [31:0] t_daddr = '0, t_dwdata = '0;
    logic [15:0] t_dump_addr;
    logic [31:0] t_dump_data, t_result, t_cycle, t_stall_cnt;
    logic [6:0]  t_dump_idx;
    logic        t_valid, t_done, t_timeout, t_end;

    run_monitor #(.CYC_MAX(16)) dut_to (
        .clk(clk), .rst(t_rst), .stall_in(t_stall), .daddr(t_daddr), .dwdata(t_dwdata),
        .dwe(t_dwe), .dump_addr(t_dump_addr), .dump_rdata(32'd0), .dump_data(t_dump_data),
        .dump_idx(t_dump_idx), .dump_valid(t_valid), .dump_ready(1'b1), .done(t_done),
        .timeout(t_timeout), .result(t_result), .cycle_count(t_cycle),
        .stall_count(t_stall_cnt), .dump_end(t_end)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_done"}, 64'(done), 0);
        chk({tag, "_timeout"}, 64'(timeout), 0);
        chk({tag, "_result"}, 64'(result), 0);
        chk({tag, "_cycle"}, 64'(cycle_count), 0);
        chk({tag, "_stall"}, 64'(stall_count), 0);
        chk({tag, "_valid"}, 64'(dump_valid), 0);
        chk({tag, "_idx"}, 64'(dump_idx), 0);
        chk({tag, "_end"}, 64'(dump_end), 0);
        chk({tag, "_addr"}, 64'(dump_addr), 50);
    endtask

    typedef struct {
        logic        r, s, w;
        logic [31:0] a, d;
        logic        e_done, e_valid;
        int unsigned e_cyc, e_stl;
        logic [31:0] e_res;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t v(input logic r, input logic s, input logic w, input logic [31:0] a,
                               input logic [31:0] d, input logic ed, input logic ev,
                               input int unsigned ec, input int unsigned es,
                               input logic [31:0] er);
        vec_t x;
        x.r = r; x.s = s; x.w = w; x.a = a; x.d = d;
        x.e_done = ed; x.e_valid = ev; x.e_cyc = ec; x.e_stl = es; x.e_res = er;
        return x;
    endfunction

    initial begin
        int k;
        logic        held;
        logic [31:0] held_data;
        logic [6:0]  held_idx;
        logic        rdy;
        logic [3:0]  pat;

        //        rst stl dwe addr dwdata        done vld cyc stl result
        vq.push_back(v(1, 0, 0, 0,   0,            0, 0,  0, 0, 0));
        vq.push_back(v(0, 0, 0, 0,   0,            0, 0,  1, 0, 0));
        vq.push_back(v(0, 1, 0, 0,   0,            0, 0,  2, 1, 0));
        vq.push_back(v(0, 0, 0, 0,   0,            0, 0,  3, 1, 0));
        vq.push_back(v(0, 0, 0, 0,   0,            0, 0,  4, 1, 0));
        vq.push_back(v(0, 1, 0, 0,   0,            0, 0,  5, 2, 0));
        vq.push_back(v(0, 0, 0, 0,   0,            0, 0,  6, 2, 0));
        vq.push_back(v(0, 0, 0, 0,   0,            0, 0,  7, 2, 0));
        vq.push_back(v(0, 0, 0, 0,   0,            0, 0,  8, 2, 0));
        vq.push_back(v(0, 1, 0, 0,   0,            0, 0,  9, 3, 0));
        vq.push_back(v(0, 0, 0, 0,   0,            0, 0, 10, 3, 0));
        vq.push_back(v(0, 0, 1, 104, 32'h11,       0, 0, 11, 3, 0));
        vq.push_back(v(0, 0, 1, 96,  32'h22,       0, 0, 12, 3, 0));
        vq.push_back(v(0, 0, 0, 100, 32'h33,       0, 0, 13, 3, 0));
        vq.push_back(v(0, 0, 0, 0,   0,            0, 0, 14, 3, 0));
        vq.push_back(v(0, 1, 0, 0,   0,            0, 0, 15, 4, 0));
        vq.push_back(v(0, 0, 0, 0,   0,            0, 0, 16, 4, 0));
        vq.push_back(v(0, 0, 0, 0,   0,            0, 0, 17, 4, 0));
        vq.push_back(v(0, 1, 0, 0,   0,            0, 0, 18, 5, 0));
        vq.push_back(v(0, 0, 0, 0,   0,            0, 0, 19, 5, 0));
        vq.push_back(v(0, 0, 0, 0,   0,            0, 0, 20, 5, 0));
        vq.push_back(v(0, 1, 1, 100, 32'hAB,       1, 0, 20, 5, 32'hAB));
        vq.push_back(v(0, 1, 1, 100, 32'h55,       1, 1, 20, 5, 32'hAB));

        #1;
        foreach (vq[i]) begin
            rst = vq[i].r; stall_in = vq[i].s; dwe = vq[i].w;
            daddr = vq[i].a; dwdata = vq[i].d;
            step();
            chk($sformatf("vec%0d_done", i), 64'(done), 64'(vq[i].e_done));
            chk($sformatf("vec%0d_valid", i), 64'(dump_valid), 64'(vq[i].e_valid));
            chk($sformatf("vec%0d_cycle", i), 64'(cycle_count), 64'(vq[i].e_cyc));
            chk($sformatf("vec%0d_stall", i), 64'(stall_count), 64'(vq[i].e_stl));
            chk($sformatf("vec%0d_result", i), 64'(result), 64'(vq[i].e_res));
            chk($sformatf("vec%0d_timeout", i), 64'(timeout), 0);
        end
        stall_in = 0; dwe = 0;

        // Backpressure held low: first word must sit still.
        repeat (3) begin
            step();
            chk("hold_valid", 64'(dump_valid), 1);
            chk("hold_idx", 64'(dump_idx), 0);
            chk("hold_data", 64'(dump_data), 150);
        end

        // Irregular ready: every index once, in order, stable while stalled.
        pat = 4'b1001;
        k = 0;
        held = 0;
        held_data = '0;
        held_idx = '0;
        for (int c = 0; c < 600 && k < 60; c++) begin
            rdy = pat[c % 4] ^ ($urandom_range(0, 3) == 0);
            dump_ready = rdy;
            #1;
            if (held) begin
                chk("stall_valid", 64'(dump_valid), 1);
                chk("stall_data", 64'(dump_data), 64'(held_data));
                chk("stall_idx", 64'(dump_idx), 64'(held_idx));
            end
            held = 0;
            if (dump_valid) begin
                chk("rnd_idx", 64'(dump_idx), 64'(k));
                chk("rnd_data", 64'(dump_data), 64'(150 + 3 * k));
                chk("rnd_end", 64'(dump_end), 64'(rdy && k == 59));
                if (rdy) k++;
                else begin
                    held = 1;
                    held_data = dump_data;
                    held_idx = dump_idx;
                end
            end
            step();
        end
        chk("rnd_all_words", 64'(k), 60);

        // HALT: everything frozen, core activity ignored.
        dump_ready = 1; stall_in = 1; dwe = 1; daddr = 100; dwdata = 32'hFF;
        repeat (50) step();
        chk("halt_valid", 64'(dump_valid), 0);
        chk("halt_end", 64'(dump_end), 0);
        chk("halt_done", 64'(done), 1);
        chk("halt_cycle", 64'(cycle_count), 20);
        chk("halt_stall", 64'(stall_count), 5);
        chk("halt_result", 64'(result), 32'hAB);
        chk("halt_timeout", 64'(timeout), 0);

        // Second run: full-rate dump with ready held high.
        rst = 1; stall_in = 0; dwe = 0;
        step();
        check_zero("rst2");
        rst = 0;
        step();
        stall_in = 1;
        step();
        stall_in = 0;
        step();
        dwe = 1; daddr = 100; dwdata = 32'h1234;
        step();
        dwe = 0;
        chk("run2_done", 64'(done), 1);
        chk("run2_cycle", 64'(cycle_count), 3);
        chk("run2_stall", 64'(stall_count), 1);
        chk("run2_result", 64'(result), 32'h1234);
        chk("run2_valid_early", 64'(dump_valid), 0);
        step();
        for (int j = 0; j < 60; j++) begin
            chk("fast_valid", 64'(dump_valid), 1);
            chk("fast_idx", 64'(dump_idx), 64'(j));
            chk("fast_data", 64'(dump_data), 64'(150 + 3 * j));
            chk("fast_end", 64'(dump_end), 64'(j == 59));
            step();
        end
        chk("fast_after_valid", 64'(dump_valid), 0);
        chk("fast_after_end", 64'(dump_end), 0);

        // Third run: reset in the middle of the dump.
        rst = 1;
        step();
        rst = 0;
        dwe = 1; daddr = 100; dwdata = 32'h77;
        step();
        dwe = 0;
        for (int c = 0; c < 100 && !(dump_valid && dump_idx == 7'd30); c++) step();
        chk("mid_reach30", 64'(dump_valid && dump_idx == 7'd30), 1);
        rst = 1;
        step();
        rst = 0;
        check_zero("midrst");
        step();
        chk("midrst_run_cycle", 64'(cycle_count), 1);
        chk("midrst_run_valid", 64'(dump_valid), 0);

        // Timeout instance: CYC_MAX = 16.
        t_rst = 1;
        step();
        t_rst = 0;
        repeat (15) step();
        chk("to_cycle15", 64'(t_cycle), 15);
        chk("to_not_yet", 64'(t_timeout), 0);
        step();
        chk("to_timeout", 64'(t_timeout), 1);
        chk("to_cycle16", 64'(t_cycle), 16);
        chk("to_done", 64'(t_done), 0);
        t_stall = 1; t_dwe = 1; t_daddr = 100; t_dwdata = 32'h5;
        repeat (5) step();
        chk("to_hold_cycle", 64'(t_cycle), 16);
        chk("to_hold_stall", 64'(t_stall_cnt), 0);
        chk("to_hold_done", 64'(t_done), 0);
        chk("to_hold_valid", 64'(t_valid), 0);
        t_rst = 1; t_stall = 0; t_dwe = 0;
        step();
        t_rst = 0;
        repeat (15) step();
        t_dwe = 1; t_dwdata = 32'h9;
        step();
        t_dwe = 0;
        chk("race_done", 64'(t_done), 1);
        chk("race_timeout", 64'(t_timeout), 0);
        chk("race_cycle", 64'(t_cycle), 15);
        chk("race_result", 64'(t_result), 9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
